calc_sequencer: RTL and testbench

//  Sequencing controller for the calculator datapath.
//  - Takes decoded keypad events and accumulates two decimal operands.
//  - Drives the alumdl operand/opcode inputs and samples its result after a fixed settle time.
//  - Converts the signed result to decimal digits and streams them, MSD first, to ledtube.
//  - Replaces the free-running flag/delay counters with one explicit FSM.

---
 rtl/calc_pkg.sv | 41 ++++
 rtl/bin2dec_serial.sv | 51 +++++
 rtl/calc_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants, key/opcode encodings and FSM state type for the calculator sequencer.
package calc_pkg;

  localparam int unsigned W        = 11;
  localparam int unsigned ALU_LAT  = 3;
  localparam int unsigned EMIT_GAP = 8;
  localparam int unsigned MAXDIG   = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DBUF_W   = 4 * MAXDIG;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  localparam logic [3:0] KEY_OR  = 4'hA;
  localparam logic [3:0] KEY_AND = 4'hB;
  localparam logic [3:0] KEY_SLT = 4'hC;
  localparam logic [3:0] KEY_SUB = 4'hD;
  localparam logic [3:0] KEY_ADD = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_OPA, S_OPB, S_EXEC, S_CONV, S_EMIT, S_DONE
  } state_t;

  function automatic logic [2:0] key_to_op(input logic [3:0] k);
    case (k)
      KEY_OR:  key_to_op = OP_OR;
      KEY_AND: key_to_op = OP_AND;
      KEY_SLT: key_to_op = OP_SLT;
      KEY_SUB: key_to_op = OP_SUB;
      default: key_to_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/bin2dec_serial.sv
// Restoring shift-subtract divide-by-10: one quotient bit per cycle, W cycles per digit.
module bin2dec_serial
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic [W-1:0] quot,
  output logic [3:0]   rem,
  output logic         done
);

  localparam int unsigned BW = $clog2(W);

  logic [BW-1:0] bit_cnt;
  logic          run;
  logic [4:0]    trial;
  logic          ge;

  // quot holds the remaining dividend bits on top and collects quotient bits at the bottom
  assign trial = {rem, quot[W-1]};
  assign ge    = (trial >= 5'd10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot    <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quot    <= din;
        rem     <= '0;
        bit_cnt <= '0;
        run     <= 1'b1;
      end else if (run) begin
        quot    <= {quot[W-2:0], ge};
        rem     <= ge ? 4'(trial - 5'd10) : trial[3:0];
        bit_cnt <= bit_cnt + BW'(1);
        if (bit_cnt == BW'(W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: operand entry, ALU drive/sample, decimal conversion and digit streaming.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_cs,
  output logic         alu_carry_in,
  input  logic [W-1:0] alu_s,
  output logic [3:0]   disp_num,
  output logic [2:0]   disp_len,
  output logic         disp_valid,
  output logic         busy,
  output logic         ovf
);

  localparam int unsigned XW = W + 1;

  state_t              state, state_nxt;
  logic [W-1:0]        cur, cur_nxt, chain, chain_nxt;
  logic [1:0]          ndig, ndig_nxt, dcnt, dcnt_nxt;
  logic                neg, neg_nxt, sign_pend, sign_pend_nxt;
  logic [DBUF_W-1:0]   dbuf, dbuf_nxt, src_buf;
  logic [CNT_W-1:0]    gcnt, gcnt_nxt;
  logic [W-1:0]        alu_a_nxt, alu_b_nxt;
  logic [2:0]          alu_cs_nxt, disp_len_nxt;
  logic [3:0]          disp_num_nxt;
  logic                disp_valid_nxt, ovf_nxt, emit_go, emit_first;

  logic                is_dig, is_op;
  logic                arith_c, b_sign_c, sovf_c, neg_c, res_ovf_c;
  logic [XW-1:0]       r_ext_c, mag_ext_c, mag_m1_c, mag_m2_c;
  logic [W-1:0]        mag_c, div_din_c, div_quot;
  logic [3:0]          div_rem;
  logic                div_start_c, div_done;

  assign alu_carry_in = 1'b0;
  assign is_dig = (key_code <= 4'd9);
  assign is_op  = (key_code >= KEY_OR) && (key_code <= KEY_ADD);

  // Signed overflow flips the true sign; an extra top bit recovers the real value (e.g. 999+999)
  assign arith_c   = (alu_cs == OP_ADD) || (alu_cs == OP_SUB);
  assign b_sign_c  = (alu_cs == OP_SUB) ? ~alu_b[W-1] : alu_b[W-1];
  assign sovf_c    = arith_c && (alu_a[W-1] == b_sign_c) && (alu_s[W-1] != alu_a[W-1]);
  assign r_ext_c   = {arith_c & (alu_s[W-1] ^ sovf_c), alu_s};
  assign neg_c     = r_ext_c[W];
  assign mag_ext_c = neg_c ? (~r_ext_c + XW'(1)) : r_ext_c;
  assign res_ovf_c = sovf_c || (mag_ext_c > XW'(999));
  assign mag_m1_c  = (mag_ext_c >= XW'(1000)) ? mag_ext_c - XW'(1000) : mag_ext_c;
  assign mag_m2_c  = (mag_m1_c >= XW'(1000)) ? mag_m1_c - XW'(1000) : mag_m1_c;
  assign mag_c     = W'(mag_m2_c);

  bin2dec_serial u_b2d (
    .clk   (clk),
    .rst   (rst),
    .start (div_start_c),
    .din   (div_din_c),
    .quot  (div_quot),
    .rem   (div_rem),
    .done  (div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    ndig_nxt       = ndig;
    chain_nxt      = chain;
    neg_nxt        = neg;
    sign_pend_nxt  = sign_pend;
    dbuf_nxt       = dbuf;
    dcnt_nxt       = dcnt;
    gcnt_nxt       = gcnt;
    alu_a_nxt      = alu_a;
    alu_b_nxt      = alu_b;
    alu_cs_nxt     = alu_cs;
    disp_num_nxt   = disp_num;
    disp_len_nxt   = disp_len;
    disp_valid_nxt = 1'b0;
    ovf_nxt        = ovf;
    div_start_c    = 1'b0;
    div_din_c      = mag_c;
    emit_go        = 1'b0;
    emit_first     = 1'b0;
    src_buf        = dbuf;

    case (state)
      S_IDLE, S_OPA, S_OPB, S_DONE: begin
        if (key_valid) begin
          if (is_dig) begin
            if (state == S_IDLE || state == S_DONE) begin
              cur_nxt        = W'(key_code);
              ndig_nxt       = 2'd1;
              state_nxt      = S_OPA;
              disp_num_nxt   = key_code;
              disp_len_nxt   = 3'd1;
              disp_valid_nxt = 1'b1;
            end else if (ndig < 2'(MAXDIG)) begin
              cur_nxt        = W'(cur * W'(10)) + W'(key_code);
              ndig_nxt       = ndig + 2'd1;
              disp_num_nxt   = key_code;
              disp_len_nxt   = 3'(ndig) + 3'd1;
              disp_valid_nxt = 1'b1;
            end
          end else if (is_op) begin
            if (!(state == S_OPB && ndig != 2'd0)) begin
              case (state)
                S_IDLE:  alu_a_nxt = '0;
                S_OPA:   alu_a_nxt = cur;
                S_DONE:  alu_a_nxt = chain;
                default: alu_a_nxt = alu_a;
              endcase
              alu_cs_nxt     = key_to_op(key_code);
              ovf_nxt        = 1'b0;
              cur_nxt        = '0;
              ndig_nxt       = '0;
              state_nxt      = S_OPB;
              disp_num_nxt   = DIG_BLANK;
              disp_len_nxt   = 3'd0;
              disp_valid_nxt = 1'b1;
            end
          end else if (state == S_OPB) begin
            alu_b_nxt = cur;
            ovf_nxt   = 1'b0;
            gcnt_nxt  = '0;
            state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        gcnt_nxt = gcnt + CNT_W'(1);
        if (gcnt == CNT_W'(ALU_LAT - 1)) begin
          neg_nxt       = neg_c;
          sign_pend_nxt = neg_c;
          ovf_nxt       = res_ovf_c;
          chain_nxt     = res_ovf_c ? '0 : alu_s;
          dbuf_nxt      = '0;
          dcnt_nxt      = '0;
          div_start_c   = 1'b1;
          div_din_c     = mag_c;
          state_nxt     = S_CONV;
        end
      end
      S_CONV: begin
        // Digits arrive LSD first; shifting each into the top leaves the MSD in the top nibble
        if (div_done) begin
          src_buf  = {div_rem, dbuf[DBUF_W-1:4]};
          dbuf_nxt = src_buf;
          dcnt_nxt = dcnt + 2'd1;
          if (div_quot == '0 || dcnt == 2'(MAXDIG - 1)) begin
            emit_go    = 1'b1;
            emit_first = 1'b1;
            gcnt_nxt   = '0;
            state_nxt  = S_EMIT;
          end else begin
            div_start_c = 1'b1;
            div_din_c   = div_quot;
          end
        end
      end
      S_EMIT: begin
        gcnt_nxt = gcnt + CNT_W'(1);
        if (gcnt == CNT_W'(EMIT_GAP - 1)) begin
          gcnt_nxt = '0;
          if (disp_len == 3'(dcnt) + 3'(neg)) state_nxt = S_DONE;
          else                                emit_go   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (emit_go) begin
      if (sign_pend) begin
        disp_num_nxt  = DIG_MINUS;
        sign_pend_nxt = 1'b0;
        dbuf_nxt      = src_buf;
      end else begin
        disp_num_nxt = src_buf[DBUF_W-1 -: 4];
        dbuf_nxt     = {src_buf[DBUF_W-5:0], 4'h0};
      end
      disp_len_nxt   = emit_first ? 3'd1 : disp_len + 3'd1;
      disp_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= '0;
      ndig       <= '0;
      chain      <= '0;
      neg        <= 1'b0;
      sign_pend  <= 1'b0;
      dbuf       <= '0;
      dcnt       <= '0;
      gcnt       <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cs     <= OP_ADD;
      disp_num   <= '0;
      disp_len   <= '0;
      disp_valid <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      cur        <= cur_nxt;
      ndig       <= ndig_nxt;
      chain      <= chain_nxt;
      neg        <= neg_nxt;
      sign_pend  <= sign_pend_nxt;
      dbuf       <= dbuf_nxt;
      dcnt       <= dcnt_nxt;
      gcnt       <= gcnt_nxt;
      alu_a      <= alu_a_nxt;
      alu_b      <= alu_b_nxt;
      alu_cs     <= alu_cs_nxt;
      disp_num   <= disp_num_nxt;
      disp_len   <= disp_len_nxt;
      disp_valid <= disp_valid_nxt;
      busy       <= (state_nxt == S_EXEC) || (state_nxt == S_CONV) || (state_nxt == S_EMIT);
      ovf        <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer with a behavioural alumdl model.
`timescale 1ns/1ps
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [10:0] alu_a, alu_b, alu_s;
  logic [2:0]  alu_cs;
  logic        alu_carry_in;
  logic [3:0]  disp_num;
  logic [2:0]  disp_len;
  logic        disp_valid, busy, ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cs       (alu_cs),
    .alu_carry_in (alu_carry_in),
    .alu_s        (alu_s),
    .disp_num     (disp_num),
    .disp_len     (disp_len),
    .disp_valid   (disp_valid),
    .busy         (busy),
    .ovf          (ovf)
  );

  // alumdl model
  always_comb begin
    case (alu_cs)
      3'b000:  alu_s = alu_a & alu_b;
      3'b001:  alu_s = alu_a | alu_b;
      3'b010:  alu_s = alu_a + alu_b;
      3'b011:  alu_s = alu_a - alu_b;
      3'b100:  alu_s = ($signed(alu_a) < $signed(alu_b)) ? 11'd1 : 11'd0;
      default: alu_s = 11'd0;
    endcase
  end

  // Result-digit scoreboard: every strobe while busy must match the next expected {num,len}
  always @(negedge clk) begin
    logic [6:0] e;
    if (!rst && disp_valid && busy) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL emit_extra: got num=%h len=%0d, required no strobe", disp_num, disp_len);
      end else begin
        e = exp_q.pop_front();
        if ({disp_num, disp_len} !== e) begin
          n_bad++;
          $display("FAIL emit_digit: got num=%h len=%0d, required num=%h len=%0d",
                   disp_num, disp_len, e[6:3], e[2:0]);
        end
      end
    end
  end

  task automatic push_result(input int val, input bit arith);
    int mag, nd, len, d;
    bit is_neg;
    is_neg = arith && (val < 0);
    mag = (val < 0) ? -val : val;
    if (mag > 999) mag = mag % 1000;
    len = 0;
    if (is_neg) begin
      len++;
      exp_q.push_back({4'hA, 3'(len)});
    end
    nd = (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
    for (int i = nd - 1; i >= 0; i--) begin
      d = (mag / (10 ** i)) % 10;
      len++;
      exp_q.push_back({4'(d), 3'(len)});
    end
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, cyc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing: %0d digits outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_first_emit(input string name);
    int cyc = 0;
    while (!(disp_valid && busy) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!(disp_valid && busy)) begin
      n_bad++;
      $display("FAIL %s_no_emit: no digit strobe within %0d cycles, required one", name, cyc);
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({alu_a, alu_b, disp_num, disp_len, disp_valid, busy, ovf, alu_carry_in} !== 33'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got a=%0d b=%0d num=%h len=%0d v=%b busy=%b ovf=%b, required all 0",
               alu_a, alu_b, disp_num, disp_len, disp_valid, busy, ovf);
    end
    n_cmp++;
    if (alu_cs !== 3'b010) begin
      n_bad++;
      $display("FAIL reset_alu_cs: got %b, required 010", alu_cs);
    end
  endtask

  task automatic test_add;
    press(4'd1);
    n_cmp++;
    if ({disp_valid, disp_num, disp_len} !== {1'b1, 4'd1, 3'd1}) begin
      n_bad++;
      $display("FAIL add_echo1: got v=%b num=%h len=%0d, required v=1 num=1 len=1", disp_valid, disp_num, disp_len);
    end
    press(4'd2);
    n_cmp++;
    if ({disp_valid, disp_num, disp_len} !== {1'b1, 4'd2, 3'd2}) begin
      n_bad++;
      $display("FAIL add_echo2: got v=%b num=%h len=%0d, required v=1 num=2 len=2", disp_valid, disp_num, disp_len);
    end
    press(4'hE);
    n_cmp++;
    if (disp_len !== 3'd0) begin
      n_bad++;
      $display("FAIL add_op_clear: got len=%0d, required 0", disp_len);
    end
    press(4'd3);
    press(4'd4);
    press(4'hF);
    push_result(46, 1'b1);
    n_cmp++;
    if ({alu_a, alu_b, alu_cs, busy} !== {11'd12, 11'd34, 3'b010, 1'b1}) begin
      n_bad++;
      $display("FAIL add_alu_in: got a=%0d b=%0d cs=%b busy=%b, required a=12 b=34 cs=010 busy=1",
               alu_a, alu_b, alu_cs, busy);
    end
    wait_done("add");
    n_cmp++;
    if ({ovf, disp_len} !== {1'b0, 3'd2}) begin
      n_bad++;
      $display("FAIL add_final: got ovf=%b len=%0d, required ovf=0 len=2", ovf, disp_len);
    end
  endtask

  task automatic test_sub_chain;
    press(4'd5); press(4'hD); press(4'd9); press(4'hF);
    push_result(-4, 1'b1);
    wait_done("sub");
    press(4'hE);
    n_cmp++;
    if (alu_a !== 11'h7FC) begin
      n_bad++;
      $display("FAIL chain_a: got %0d, required 2044 (-4)", alu_a);
    end
    press(4'd1); press(4'hF);
    push_result(-3, 1'b1);
    wait_done("chain");
  endtask

  task automatic test_ovf;
    press(4'd9); press(4'd9); press(4'd9); press(4'hE);
    press(4'd9); press(4'd9); press(4'd9); press(4'hF);
    push_result(1998, 1'b1);
    wait_done("ovf");
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: got %b, required 1", ovf);
    end
    press(4'hE);
    n_cmp++;
    if ({ovf, alu_a} !== {1'b0, 11'd0}) begin
      n_bad++;
      $display("FAIL ovf_clear: got ovf=%b a=%0d, required ovf=0 a=0", ovf, alu_a);
    end
    press(4'd1); press(4'hF);
    push_result(1, 1'b1);
    wait_done("ovf_chain");
  endtask

  task automatic test_zero_slt;
    press(4'd7); press(4'hD); press(4'd7); press(4'hF);
    push_result(0, 1'b1);
    wait_done("zero");
    n_cmp++;
    if (disp_len !== 3'd1) begin
      n_bad++;
      $display("FAIL zero_len: got %0d, required 1", disp_len);
    end
    press(4'd3); press(4'hC); press(4'd5); press(4'hF);
    push_result(1, 1'b0);
    wait_done("slt");
  endtask

  task automatic test_digit_drop;
    press(4'd1); press(4'd2); press(4'd3);
    n_cmp++;
    if ({disp_valid, disp_num, disp_len} !== {1'b1, 4'd3, 3'd3}) begin
      n_bad++;
      $display("FAIL drop_echo3: got v=%b num=%h len=%0d, required v=1 num=3 len=3", disp_valid, disp_num, disp_len);
    end
    press(4'd4);
    n_cmp++;
    if (disp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_echo4: got v=%b, required 0", disp_valid);
    end
    press(4'hE);
    n_cmp++;
    if (alu_a !== 11'd123) begin
      n_bad++;
      $display("FAIL drop_operand: got %0d, required 123", alu_a);
    end
    press(4'd5); press(4'hF);
    push_result(128, 1'b1);
    wait_done("drop");
  endtask

  task automatic test_busy_key;
    press(4'd4); press(4'd5); press(4'd6); press(4'hE); press(4'd1); press(4'hF);
    push_result(457, 1'b1);
    wait_first_emit("busy");
    press(4'd9);
    press(4'hE);
    wait_done("busy");
    n_cmp++;
    if (disp_len !== 3'd3) begin
      n_bad++;
      $display("FAIL busy_len: got %0d, required 3", disp_len);
    end
    press(4'hF);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_eq_ignored: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_emit;
    press(4'd1); press(4'd2); press(4'd3); press(4'hE);
    press(4'd4); press(4'd5); press(4'd6); press(4'hF);
    push_result(579, 1'b1);
    wait_first_emit("rst");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({alu_a, alu_b, disp_num, disp_len, disp_valid, busy, ovf} !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got a=%0d b=%0d num=%h len=%0d v=%b busy=%b ovf=%b, required all 0",
               alu_a, alu_b, disp_num, disp_len, disp_valid, busy, ovf);
    end
    n_cmp++;
    if (alu_cs !== 3'b010) begin
      n_bad++;
      $display("FAIL rst_mid_alu_cs: got %b, required 010", alu_cs);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    press(4'd8);
    n_cmp++;
    if ({disp_valid, disp_num, disp_len, busy} !== {1'b1, 4'd8, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_idle_echo: got v=%b num=%h len=%0d busy=%b, required v=1 num=8 len=1 busy=0",
               disp_valid, disp_num, disp_len, busy);
    end
    press(4'hF);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL opa_eq_ignored: got busy=%b, required 0", busy);
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_add;
    test_sub_chain;
    test_ovf;
    test_zero_slt;
    test_digit_drop;
    test_busy_key;
    test_reset_mid_emit;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
